// File: rtl/greycode_pkg.sv
// Shared definitions for the counter-channel select sequencer.
//   N_CH            number of mux channels (005,011,023,047,097,197,clk)
//   CH_005..CH_CLK  channel indices; CH_CLK is the mux default arm
//   state_t         sequencer state encoding
//   ch2sel()        channel index -> 6-bit mux select code
package greycode_pkg;

  localparam int N_CH = 7;

  localparam logic [2:0] CH_005 = 3'd0;
  localparam logic [2:0] CH_011 = 3'd1;
  localparam logic [2:0] CH_023 = 3'd2;
  localparam logic [2:0] CH_047 = 3'd3;
  localparam logic [2:0] CH_097 = 3'd4;
  localparam logic [2:0] CH_197 = 3'd5;
  localparam logic [2:0] CH_CLK = 3'd6;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_DWELL   = 2'd1,
    ST_WAITACK = 2'd2
  } state_t;

  // Channel k<6 drives only bit (5-k); the clk channel is the all-zero default arm.
  function automatic logic [5:0] ch2sel(input logic [2:0] idx);
    if (idx >= CH_CLK) return 6'b000000;
    return 6'b100000 >> idx;
  endfunction

endpackage

// File: rtl/sel_scan_timer.sv
// Shared settle/dwell counter.
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_clr         restart the count at 0
//   i_inc         count one cycle (holds once expired)
//   i_limit       number of cycles in the current interval (0 acts like 1)
//   o_expired     count has reached limit-1, or beyond after a limit change
module sel_scan_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  localparam logic [W:0] ONE = 1;

  logic [W-1:0] cnt;

  // cnt >= limit-1, evaluated in W+1 bits so a shrinking limit never wraps.
  assign o_expired = ({1'b0, cnt} + ONE) >= {1'b0, i_limit};

  always_ff @(posedge i_clk) begin
    if (i_rst)                   cnt <= '0;
    else if (i_clr)              cnt <= '0;
    else if (i_inc && !o_expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/sel_scan.sv
// Sequencer for the counter-channel output mux: auto-scan with programmable dwell
// or manual channel tracking, settle-then-valid signalling and optional ack backpressure.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_mode         0 manual, 1 auto-scan
//   i_man_sel      manual channel index (7 maps to 6)
//   i_dwell        auto: valid cycles per channel (0 maps to 1)
//   i_hold         auto: freeze on current channel
//   i_ack_en       advance requires ack of current sample
//   i_ack          consumer accepted sample
//   o_sel          mux select code
//   o_ch           current channel index
//   o_valid        mux output stable for o_ch
//   o_frame        one-cycle pulse when the scan wraps to channel 0
//
// state      | meaning
// SETTLE     | select just changed, waiting for the mux output to settle
// DWELL      | output valid; manual hold or auto dwell count running
// WAITACK    | auto dwell expired, waiting for consumer ack before advancing
module sel_scan #(
  parameter int N_CH    = 7,
  parameter int DWELL_W = 8,
  parameter int SETTLE  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mode,
  input  logic [2:0]         i_man_sel,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_hold,
  input  logic               i_ack_en,
  input  logic               i_ack,
  output logic [5:0]         o_sel,
  output logic [2:0]         o_ch,
  output logic               o_valid,
  output logic               o_frame
);
  import greycode_pkg::*;

  localparam logic [2:0] LAST_CH = 3'(N_CH - 1);

  state_t             state, nxt_state;
  logic               ack_flag;
  logic [2:0]         man_idx, nxt_ch, ld_idx;
  logic               man_resel, ld, frame_set;
  logic               tmr_clr, tmr_inc, tmr_expired;
  logic [DWELL_W-1:0] dwell_lim, tmr_limit;

  assign man_idx   = (i_man_sel == 3'd7) ? CH_CLK : i_man_sel;
  assign man_resel = !i_mode && (man_idx != o_ch);
  assign nxt_ch    = (o_ch == LAST_CH) ? 3'd0 : o_ch + 3'd1;
  assign dwell_lim = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
  assign tmr_limit = (state == ST_SETTLE) ? DWELL_W'(SETTLE) : dwell_lim;

  sel_scan_timer #(.W(DWELL_W)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (tmr_clr),
    .i_inc     (tmr_inc),
    .i_limit   (tmr_limit),
    .o_expired (tmr_expired)
  );

  // A channel load (manual reselect or auto advance) always returns to SETTLE
  // with a fresh counter and a cleared ack flag.
  always_comb begin
    nxt_state = state;
    ld        = 1'b0;
    ld_idx    = o_ch;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    frame_set = 1'b0;
    case (state)
      ST_SETTLE: begin
        if (man_resel) begin
          ld = 1'b1; ld_idx = man_idx; tmr_clr = 1'b1;
        end else if (tmr_expired) begin
          nxt_state = ST_DWELL; tmr_clr = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_DWELL: begin
        if (man_resel) begin
          ld = 1'b1; ld_idx = man_idx; tmr_clr = 1'b1; nxt_state = ST_SETTLE;
        end else if (!i_mode) begin
          // Keeping the count at 0 in manual makes a later switch to auto start a fresh dwell.
          tmr_clr = 1'b1;
        end else if (!tmr_expired) begin
          tmr_inc = 1'b1;
        end else if (i_hold) begin
          nxt_state = ST_DWELL;
        end else if (i_ack_en && !ack_flag && !i_ack) begin
          nxt_state = ST_WAITACK;
        end else begin
          ld = 1'b1; ld_idx = nxt_ch; tmr_clr = 1'b1; nxt_state = ST_SETTLE;
          frame_set = (o_ch == LAST_CH);
        end
      end
      ST_WAITACK: begin
        if (man_resel) begin
          ld = 1'b1; ld_idx = man_idx; tmr_clr = 1'b1; nxt_state = ST_SETTLE;
        end else if (!i_mode) begin
          nxt_state = ST_DWELL; tmr_clr = 1'b1;
        end else if (!i_hold && i_ack) begin
          ld = 1'b1; ld_idx = nxt_ch; tmr_clr = 1'b1; nxt_state = ST_SETTLE;
          frame_set = (o_ch == LAST_CH);
        end
      end
      default: begin
        nxt_state = ST_SETTLE; tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_SETTLE;
      o_ch     <= CH_005;
      o_sel    <= 6'b100000;
      o_valid  <= 1'b0;
      o_frame  <= 1'b0;
      ack_flag <= 1'b0;
    end else begin
      state   <= nxt_state;
      o_frame <= frame_set;
      // Valid follows the next state, so it drops on the same edge any select change lands.
      o_valid <= (nxt_state != ST_SETTLE);
      if (ld) begin
        o_ch  <= ld_idx;
        o_sel <= ch2sel(ld_idx);
      end
      if (ld)                               ack_flag <= 1'b0;
      else if (state == ST_DWELL && i_ack)  ack_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sel_scan.sv
module tb_sel_scan;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_mode;
  logic [2:0] i_man_sel;
  logic [7:0] i_dwell;
  logic       i_hold;
  logic       i_ack_en;
  logic       i_ack;
  logic [5:0] o_sel;
  logic [2:0] o_ch;
  logic       o_valid;
  logic       o_frame;

  typedef struct packed {
    logic [2:0] ch;
    logic [5:0] sel;
    logic       valid;
    logic       frame;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 i_clk = ~i_clk;

  sel_scan #(.N_CH(7), .DWELL_W(8), .SETTLE(2)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_mode    (i_mode),
    .i_man_sel (i_man_sel),
    .i_dwell   (i_dwell),
    .i_hold    (i_hold),
    .i_ack_en  (i_ack_en),
    .i_ack     (i_ack),
    .o_sel     (o_sel),
    .o_ch      (o_ch),
    .o_valid   (o_valid),
    .o_frame   (o_frame)
  );

  function automatic logic [5:0] sel_of(input int ch);
    logic [5:0] one;
    one = 6'b000001;
    if (ch >= 6) return 6'b000000;
    return one << (5 - ch);
  endfunction

  // Queue the expectation for the coming edge, advance one cycle, then compare.
  task automatic step(input string tag, input int ch, input bit valid, input bit frame);
    exp_t e, got;
    e.ch    = 3'(ch);
    e.sel   = sel_of(ch);
    e.valid = valid;
    e.frame = frame;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    e   = sb.pop_front();
    got = {o_ch, o_sel, o_valid, o_frame};
    n_checks++;
    assert (got === e) else begin
      n_errors++;
      $error("FAIL %s: observed ch=%0d sel=%b valid=%b frame=%b, expected ch=%0d sel=%b valid=%b frame=%b",
             tag, o_ch, o_sel, o_valid, o_frame, e.ch, e.sel, e.valid, e.frame);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_mode = 1'b1; i_man_sel = 3'd0; i_dwell = 8'd3;
    i_hold = 1'b0; i_ack_en = 1'b0; i_ack = 1'b0;

    // Reset state, then full auto scan: 2 settle + 3 valid cycles per channel.
    step("reset", 0, 0, 0);
    i_rst = 1'b0;
    for (int k = 1; k <= 40; k++)
      step("scan", (k / 5) % 7, (k % 5) >= 2, (k % 5 == 0) && ((k / 5) % 7 == 0));

    // Manual tracking: channel 4, then index 7 maps to the clk channel.
    i_mode = 1'b0; i_man_sel = 3'd4;
    step("man4_sel", 4, 0, 0);
    step("man4_settle", 4, 0, 0);
    step("man4_valid", 4, 1, 0);
    for (int k = 0; k < 5; k++) step("man4_stay", 4, 1, 0);
    i_man_sel = 3'd7;
    step("man7_sel", 6, 0, 0);
    step("man7_settle", 6, 0, 0);
    step("man7_valid", 6, 1, 0);

    // Ack backpressure: dwell 2, no ack keeps the channel for 50+ cycles.
    i_mode = 1'b1; i_dwell = 8'd2; i_ack_en = 1'b1;
    step("wa_dwell", 6, 1, 0);
    step("wa_enter", 6, 1, 0);
    for (int k = 0; k < 50; k++) step("wa_wait", 6, 1, 0);
    i_ack = 1'b1;
    step("wa_ack_wrap", 0, 0, 1);
    i_ack = 1'b0;
    step("wa_settle0", 0, 0, 0);
    step("wa_valid0", 0, 1, 0);
    step("wa_dwell0", 0, 1, 0);
    i_ack = 1'b1;                      // ack in the expiry cycle
    step("ack_at_expiry", 1, 0, 0);
    i_ack = 1'b0;
    step("sticky_settle", 1, 0, 0);
    step("sticky_valid", 1, 1, 0);
    i_ack = 1'b1;                      // early ack is remembered
    step("sticky_ack", 1, 1, 0);
    i_ack = 1'b0;
    step("sticky_adv", 2, 0, 0);

    // Hold across expiry, then dwell=0 acts as one valid cycle.
    i_ack_en = 1'b0;
    step("h_settle2", 2, 0, 0);
    step("h_valid2", 2, 1, 0);
    step("h_dwell2", 2, 1, 0);
    step("h_adv3", 3, 0, 0);
    step("h_settle3", 3, 0, 0);
    step("h_valid3", 3, 1, 0);
    i_hold = 1'b1;
    step("h_dwell3", 3, 1, 0);
    for (int k = 0; k < 10; k++) step("h_held", 3, 1, 0);
    i_hold = 1'b0;
    step("h_release", 4, 0, 0);
    i_dwell = 8'd0;
    step("d0_settle", 4, 0, 0);
    step("d0_valid", 4, 1, 0);
    step("d0_adv", 5, 0, 0);
    step("d0_settle5", 5, 0, 0);
    step("d0_valid5", 5, 1, 0);

    // Reset in the middle of DWELL on channel 5.
    i_rst = 1'b1;
    step("rst_mid", 0, 0, 0);
    i_rst = 1'b0; i_dwell = 8'd3;
    for (int k = 1; k <= 12; k++)
      step("rescan", (k / 5) % 7, (k % 5) >= 2, 1'b0);

    // Auto -> manual on the same channel keeps valid; reselect in SETTLE restarts it.
    i_mode = 1'b0; i_man_sel = 3'd2;
    for (int k = 0; k < 3; k++) step("a2m_same", 2, 1, 0);
    i_man_sel = 3'd1;
    step("m1_sel", 1, 0, 0);
    step("m1_settle", 1, 0, 0);
    i_man_sel = 3'd0;
    step("m0_restart", 0, 0, 0);
    step("m0_settle", 0, 0, 0);
    step("m0_valid", 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
